// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences the shared MIPS datapath (ALU, register
// file, PC, unified memory) through Fetch/Decode/Execute/Memory/Writeback.
// Supports R-format, lw, sw, beq, bne and j; flags unsupported opcodes.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset (-> FETCH)
//   opcode[5:0]          instruction[31:26] from the instruction register
//   mem_ready            memory access completes this cycle
//   pc_write, pc_write_cond, branch_ne, pc_source[1:0]   PC update control
//   i_or_d, mem_read, mem_write, ir_write                memory/IR control
//   mem_to_reg, reg_dst, reg_write                       register file control
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]               ALU control
//   illegal_op, instr_done                               one-cycle status pulses
//   state[3:0]                                           current state (debug)
//
// Outputs are decoded combinationally from the registered state (plus opcode
// and mem_ready) so every control takes effect in the cycle of its state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  logic [3:0] state_q, state_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Next-state and control decode; everything held at 0 while reset is high
  // so an abandoned instruction cannot assert a write enable.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          state_d   = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          // Branch target is computed speculatively into ALUOut here.
          alu_src_b = SRCB_IMMSH;
          unique case (opcode)
            OP_RTYPE:      state_d = S_R_EXEC;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? S_FETCH : S_MEM_WRITE;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
          branch_ne     = (opcode == OP_BNE);
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCS_JUMP;
          instr_done = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each scoreboard entry pairs
// the inputs to drive in one cycle with the state and controls expected in
// that cycle; entries are queued per instruction and consumed cycle by cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  // Enables/status: {illegal_op, instr_done, pc_write, pc_write_cond,
  //                  ir_write, mem_read, mem_write, reg_write, i_or_d}
  localparam logic [8:0] F_ILL  = 9'h100;
  localparam logic [8:0] F_DONE = 9'h080;
  localparam logic [8:0] F_PCW  = 9'h040;
  localparam logic [8:0] F_PCWC = 9'h020;
  localparam logic [8:0] F_IRW  = 9'h010;
  localparam logic [8:0] F_MRD  = 9'h008;
  localparam logic [8:0] F_MWR  = 9'h004;
  localparam logic [8:0] F_RW   = 9'h002;
  localparam logic [8:0] F_IORD = 9'h001;

  // Selects: {branch_ne, alu_src_a, alu_src_b[1:0], alu_op[1:0],
  //           pc_source[1:0], reg_dst, mem_to_reg}
  localparam logic [9:0] S_FETCH = 10'h040;  // b=01
  localparam logic [9:0] S_DEC   = 10'h0C0;  // b=11
  localparam logic [9:0] S_MADDR = 10'h180;  // a=1 b=10
  localparam logic [9:0] S_MWB   = 10'h001;  // mem_to_reg
  localparam logic [9:0] S_REXE  = 10'h120;  // a=1 op=10
  localparam logic [9:0] S_RWB   = 10'h002;  // reg_dst
  localparam logic [9:0] S_BEQ   = 10'h114;  // a=1 op=01 pcs=01
  localparam logic [9:0] S_BNE   = 10'h314;  // same plus branch_ne
  localparam logic [9:0] S_JMP   = 10'h008;  // pcs=10

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ILL = 6'b001000;

  logic [8:0] got_fl;
  logic [9:0] got_sel;
  assign got_fl  = {illegal_op, instr_done, pc_write, pc_write_cond, ir_write,
                    mem_read, mem_write, reg_write, i_or_d};
  assign got_sel = {branch_ne, alu_src_a, alu_src_b, alu_op, pc_source,
                    reg_dst, mem_to_reg};

  typedef struct packed {
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic [8:0] fl;
    logic [9:0] sel;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_instr  = 0;
  int  n_done   = 0;
  int  cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic push(input logic [5:0] op, input logic mr, input logic [3:0] st,
                      input logic [8:0] fl, input logic [9:0] sel);
    sb_t e;
    e.op = op; e.mr = mr; e.st = st; e.fl = fl; e.sel = sel;
    sb_q.push_back(e);
  endtask

  function automatic logic rnd_mr();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_fetch(input logic [5:0] op, input int stalls);
    for (int i = 0; i < stalls; i++) push(op, 1'b0, 4'd0, F_MRD, S_FETCH);
    push(op, 1'b1, 4'd0, F_MRD | F_IRW | F_PCW, S_FETCH);
  endtask

  // Queue every cycle of one instruction; mem_ready is randomised in states
  // without a memory request since it must not matter there.
  task automatic push_instr(input logic [5:0] op, input int fstall, input int mstall);
    push_fetch(op, fstall);
    if (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
        op == OP_BNE || op == OP_J)
      push(op, rnd_mr(), 4'd1, 9'h000, S_DEC);
    case (op)
      OP_R: begin
        push(op, rnd_mr(), 4'd6, 9'h000, S_REXE);
        push(op, rnd_mr(), 4'd7, F_RW | F_DONE, S_RWB);
      end
      OP_LW: begin
        push(op, rnd_mr(), 4'd2, 9'h000, S_MADDR);
        for (int i = 0; i < mstall; i++) push(op, 1'b0, 4'd3, F_MRD | F_IORD, 10'h000);
        push(op, 1'b1, 4'd3, F_MRD | F_IORD, 10'h000);
        push(op, rnd_mr(), 4'd4, F_RW | F_DONE, S_MWB);
      end
      OP_SW: begin
        push(op, rnd_mr(), 4'd2, 9'h000, S_MADDR);
        for (int i = 0; i < mstall; i++) push(op, 1'b0, 4'd5, F_MWR | F_IORD, 10'h000);
        push(op, 1'b1, 4'd5, F_MWR | F_IORD | F_DONE, 10'h000);
      end
      OP_BEQ: push(op, rnd_mr(), 4'd8, F_PCWC | F_DONE, S_BEQ);
      OP_BNE: push(op, rnd_mr(), 4'd8, F_PCWC | F_DONE, S_BNE);
      OP_J:   push(op, rnd_mr(), 4'd9, F_PCW | F_DONE, S_JMP);
      default: push(op, rnd_mr(), 4'd1, F_ILL | F_DONE, S_DEC);
    endcase
    n_instr++;
  endtask

  // Called just after a rising edge: drive, sample at the falling edge.
  task automatic run_queue();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      opcode    = e.op;
      mem_ready = e.mr;
      @(negedge clk);
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("enables", 32'(got_fl), 32'(e.fl));
      check_eq("selects", 32'(got_sel), 32'(e.sel));
      if (instr_done) n_done++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_enables", 32'(got_fl), 32'd0);
    check_eq("reset_selects", 32'(got_sel), 32'd0);

    mem_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;

    // Basic sequence, then stalls, branches and an illegal opcode.
    push_instr(OP_R, 0, 0);
    push_instr(OP_LW, 0, 0);
    push_instr(OP_SW, 0, 0);
    push_instr(OP_BEQ, 0, 0);
    push_instr(OP_J, 0, 0);
    push_instr(OP_LW, 0, 3);
    push_instr(OP_R, 2, 0);
    push_instr(OP_BNE, 0, 0);
    push_instr(OP_BEQ, 1, 0);
    push_instr(OP_ILL, 0, 0);
    push_instr(OP_SW, 1, 2);
    push_instr(OP_LW, 1, 1);
    run_queue();
    check_eq("instr_done_count", 32'(n_done), 32'(n_instr));

    // Reset during a stalled store: write must drop immediately.
    push_fetch(OP_SW, 0);
    push(OP_SW, 1'b1, 4'd1, 9'h000, S_DEC);
    push(OP_SW, 1'b1, 4'd2, 9'h000, S_MADDR);
    run_queue();
    opcode    = OP_SW;
    mem_ready = 1'b0;
    #2;
    check_eq("pre_reset_state", 32'(state), 32'd5);
    check_eq("pre_reset_mem_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_reset_state", 32'(state), 32'd0);
    check_eq("mid_reset_mem_write", 32'(mem_write), 32'd0);
    check_eq("mid_reset_enables", 32'(got_fl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_reset_state", 32'(state), 32'd0);
    check_eq("post_reset_enables", 32'(got_fl), 32'(F_MRD));
    @(posedge clk);
    #1;
    check_eq("post_reset_fetch_hold", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
